// File: rtl/simd_pkg.sv
// Shared types and the lane-wise arithmetic of the simd ALU and its issue front-end.
package simd_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      OP_ADD32,
      OP_SUB32,
      OP_ADD16,
      OP_SUB16,
      OP_ADD8,
      OP_SUB8,
      OP_SEL0,
      OP_SEL1
   } op_t;

   localparam int SIMD_ISSUE_RSP_DEPTH_DFLT = 4;

   // Carries never cross lane boundaries in the packed 16/8-bit ops
   function automatic word_t simd_alu(op_t op, word_t a, word_t b);
      word_t y;
      y = '0;
      case (op)
         OP_ADD32: y = a + b;
         OP_SUB32: y = a - b;
         OP_ADD16: for (int i = 0; i < 2; i++) y[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
         OP_SUB16: for (int i = 0; i < 2; i++) y[i*16 +: 16] = a[i*16 +: 16] - b[i*16 +: 16];
         OP_ADD8:  for (int i = 0; i < 4; i++) y[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
         OP_SUB8:  for (int i = 0; i < 4; i++) y[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
         OP_SEL0:  y = a;
         OP_SEL1:  y = b;
         default:  y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/simd_issue_if.sv
// Request and response valid/ready channels between an op producer and simd_issue.
interface simd_issue_if
   import simd_pkg::*;
#(
   parameter int TAG_W = 4
);
   logic             req_vld;
   logic             req_rdy;
   op_t              req_op;
   word_t            req_a;
   word_t            req_b;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_vld;
   logic             rsp_rdy;
   word_t            rsp_y;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_vld, req_op, req_a, req_b, req_tag, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_y, rsp_tag
   );

   modport slave (
      input  req_vld, req_op, req_a, req_b, req_tag, rsp_rdy,
      output req_rdy, rsp_vld, rsp_y, rsp_tag
   );
endinterface

// File: rtl/simd.sv
// Lane-parallel ALU with a fixed one-cycle pipe and no backpressure.
module simd
   import simd_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  pass,
   input  op_t   op,
   input  word_t A,
   input  word_t B,
   output word_t Y_r,
   output logic  valid_r
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         Y_r     <= '0;
      end else begin
         valid_r <= pass;
         if (pass) Y_r <= simd_alu(op, A, B);
      end
   end

endmodule

// File: rtl/simd_issue_fifo.sv
// Response queue; pointers wrap modulo DEPTH so any depth works, not only powers of two.
module simd_issue_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full     = (cnt == FULL_CNT);
   assign empty    = (cnt == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked entirely by cnt
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/simd_issue.sv
// Issue front-end for simd: credit-gated request acceptance, tag tracking across the
// one-cycle ALU pipe, and an in-order response queue toward a backpressured consumer.
module simd_issue
   import simd_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = SIMD_ISSUE_RSP_DEPTH_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   simd_issue_if.slave bus,
   output logic        simd_pass,
   output op_t         simd_op,
   output word_t       simd_a,
   output word_t       simd_b,
   input  word_t       simd_y,
   input  logic        simd_valid,
   output logic        err_r
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(RSP_DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      word_t            y;
   } rsp_entry_t;

   logic             rst_q;
   logic             inflight_r;
   logic [TAG_W-1:0] tag_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W:0]   credits_used;
   logic             accept, push, pop, full, empty;
   logic             stray, overflow;
   rsp_entry_t       push_entry, pop_entry;

   // Queued plus in-flight results must fit, so a result never finds the queue full
   assign credits_used = {1'b0, cnt_r} + {{CNT_W{1'b0}}, inflight_r};
   assign bus.req_rdy  = ~rst_q & (credits_used < CREDIT_LIM);
   assign accept       = bus.req_vld & bus.req_rdy;

   assign simd_pass = accept;
   assign simd_op   = bus.req_op;
   assign simd_a    = bus.req_a;
   assign simd_b    = bus.req_b;

   assign stray      = simd_valid ^ inflight_r;
   assign overflow   = simd_valid & inflight_r & full;
   assign push       = simd_valid & inflight_r & ~full;
   assign push_entry = '{tag: tag_r, y: simd_y};
   assign pop        = bus.rsp_vld & bus.rsp_rdy;

   assign bus.rsp_vld = ~empty;
   assign bus.rsp_y   = pop_entry.y;
   assign bus.rsp_tag = pop_entry.tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q      <= 1'b1;
         inflight_r <= 1'b0;
         tag_r      <= '0;
         err_r      <= 1'b0;
      end else begin
         rst_q      <= 1'b0;
         inflight_r <= accept;
         if (accept) tag_r <= bus.req_tag;
         if (stray | overflow) err_r <= 1'b1;
      end
   end

   simd_issue_fifo #(
      .WIDTH ($bits(rsp_entry_t)),
      .DEPTH (RSP_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (pop_entry),
      .cnt       (cnt_r),
      .full      (full),
      .empty     (empty)
   );

endmodule
